// File: rtl/serial_pair_transmitter_if.sv
// Handshake bundle for the serial pair transmitter: parallel word-pair intake
// and serial bit-pair output. The slave modport is the transmitter side.
interface serial_pair_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_ready;
  logic             out_valid;
  logic             a;
  logic             b;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, a, b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, a, b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_transmitter.sv
// Serialises a pair of WIDTH-bit words into lock-stepped bit pairs with
// valid/ready flow control on both sides; back-to-back words stream gap-free.
//
// state | meaning
// IDLE  | no word held, outputs quiet, ready for a new pair
// SHIFT | word pair held, one bit pair presented per consumption
module serial_pair_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_pair_transmitter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [WIDTH-1:0] nxt_a, nxt_b;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             first_q, first_d, last_q, last_d;
  logic             valid_q, valid_d;
  logic             consume, accept, in_ready;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Freeing the slot on a consumed last bit lets the next word reload with no bubble.
  assign consume  = valid_q && bus.out_ready;
  assign in_ready = (state_q == IDLE) || (consume && last_q);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_q;
    nxt_a   = advance(sh_a_q);
    nxt_b   = advance(sh_b_q);

    if (accept) begin
      state_d = SHIFT;
      sh_a_d  = bus.in_a;
      sh_b_d  = bus.in_b;
      cnt_d   = '0;
      a_d     = head(bus.in_a);
      b_d     = head(bus.in_b);
      first_d = 1'b1;
      last_d  = (LAST_IDX == '0);
      valid_d = 1'b1;
    end else if (consume) begin
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        valid_d = 1'b0;
      end else begin
        sh_a_d  = nxt_a;
        sh_b_d  = nxt_b;
        cnt_d   = cnt_q + 1'b1;
        a_d     = head(nxt_a);
        b_d     = head(nxt_b);
        first_d = 1'b0;
        last_d  = (cnt_d == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      first_q <= first_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_serial_pair_transmitter.sv
// Bench for serial_pair_transmitter: MSB-first and LSB-first instances share
// stimulus and are checked every cycle against a word/index reference model.
module tb_serial_pair_transmitter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // reference model: is a word held, which word, which bit index is shown
  bit held = 1'b0;
  logic [W-1:0] wa = '0;
  logic [W-1:0] wb = '0;
  int idx = 0;

  // captures of consumed bits from each instance, first bit ends up in the MSB
  logic [W-1:0] cap_a_m, cap_b_m, cap_a_l, cap_b_l;
  int n_valid;
  int n_first;

  always #5 clk = ~clk;

  serial_pair_transmitter_if #(.WIDTH(W)) if_m ();
  serial_pair_transmitter_if #(.WIDTH(W)) if_l ();

  assign if_m.in_valid  = in_valid;
  assign if_m.in_a      = in_a;
  assign if_m.in_b      = in_b;
  assign if_m.out_ready = out_ready;
  assign if_l.in_valid  = in_valid;
  assign if_l.in_a      = in_a;
  assign if_l.in_b      = in_b;
  assign if_l.out_ready = out_ready;

  serial_pair_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_m)
  );

  serial_pair_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_l)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_capture();
    cap_a_m = '0; cap_b_m = '0; cap_a_l = '0; cap_b_l = '0;
    n_valid = 0;
    n_first = 0;
  endtask

  // One cycle: drive inputs, check both instances against the model, advance the model.
  task automatic step(input logic rn, input logic iv, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic ordy);
    logic exp_rdy, exp_am, exp_bm, exp_al, exp_bl, exp_first, exp_last;
    @(negedge clk);
    rst_n = rn; in_valid = iv; in_a = ia; in_b = ib; out_ready = ordy;
    #1;
    exp_rdy   = !held || (ordy && idx == W - 1);
    exp_am    = held ? wa[W-1-idx] : 1'b0;
    exp_bm    = held ? wb[W-1-idx] : 1'b0;
    exp_al    = held ? wa[idx] : 1'b0;
    exp_bl    = held ? wb[idx] : 1'b0;
    exp_first = held && idx == 0;
    exp_last  = held && idx == W - 1;

    check_val("in_ready_m", if_m.in_ready, exp_rdy);
    check_val("out_valid_m", if_m.out_valid, held);
    check_val("a_m", if_m.a, exp_am);
    check_val("b_m", if_m.b, exp_bm);
    check_val("first_m", if_m.out_first, exp_first);
    check_val("last_m", if_m.out_last, exp_last);
    check_val("in_ready_l", if_l.in_ready, exp_rdy);
    check_val("out_valid_l", if_l.out_valid, held);
    check_val("a_l", if_l.a, exp_al);
    check_val("b_l", if_l.b, exp_bl);
    check_val("first_l", if_l.out_first, exp_first);
    check_val("last_l", if_l.out_last, exp_last);

    if (if_m.out_valid) n_valid++;
    if (if_m.out_first) n_first++;
    if (held && ordy) begin
      cap_a_m = {cap_a_m[W-2:0], if_m.a};
      cap_b_m = {cap_b_m[W-2:0], if_m.b};
      cap_a_l = {cap_a_l[W-2:0], if_l.a};
      cap_b_l = {cap_b_l[W-2:0], if_l.b};
    end

    if (!rn) begin
      held = 1'b0;
      idx  = 0;
    end else if (iv && exp_rdy) begin
      held = 1'b1;
      wa   = ia;
      wb   = ib;
      idx  = 0;
    end else if (held && ordy) begin
      if (idx == W - 1) held = 1'b0;
      else idx++;
    end
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // single word, MSB-first and LSB-first orderings
    clear_capture();
    step(1'b1, 1'b1, 8'hB4, 8'h3C, 1'b1);
    for (int i = 0; i < W + 1; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_val("seq_a_msb", cap_a_m, 8'hB4);
    check_val("seq_b_msb", cap_b_m, 8'h3C);
    check_val("seq_a_lsb", cap_a_l, 8'h2D);
    check_val("seq_b_lsb", cap_b_l, 8'h3C);
    check_val("seq_nvalid", n_valid, 8);

    // backpressure for two cycles on bit 3
    clear_capture();
    step(1'b1, 1'b1, 8'hB4, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_val("bp_a_msb", cap_a_m, 8'hB4);
    check_val("bp_b_lsb", cap_b_l, 8'h3C);
    check_val("bp_nvalid", n_valid, 10);

    // back-to-back words with in_valid held
    clear_capture();
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < W + 1; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_val("b2b_nvalid", n_valid, 16);
    check_val("b2b_nfirst", n_first, 2);
    check_val("b2b_a2", cap_a_m, 8'h00);

    // busy rejection: offer at bit 2 only
    clear_capture();
    step(1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h77, 8'h88, 1'b1);
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_val("busy_a", cap_a_m, 8'h5A);
    check_val("busy_nvalid", n_valid, 8);

    // reset mid-word at bit 4, then a fresh word
    clear_capture();
    step(1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h99, 8'h66, 1'b1);
    step(1'b1, 1'b1, 8'h81, 8'h7E, 1'b1);
    for (int i = 0; i < W + 1; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_val("rst_nfirst", n_first, 2);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
           W'($urandom), W'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_pair_transmitter.md
SERIAL_PAIR_TRANSMITTER -- requirements
Module: serial_pair_transmitter

Interface
REQ-001 Parameter WIDTH, default 8: bits per word; SHALL be >= 1.
REQ-002 Parameter MSB_FIRST, default 1: 1 = most significant bit first, 0 = least significant bit first.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  word pair offered on in_a/in_b.
REQ-006 in_ready  output  1  block accepts word pair this cycle.
REQ-007 in_a  input  WIDTH  parallel operand A.
REQ-008 in_b  input  WIDTH  parallel operand B.
REQ-009 out_ready  input  1  downstream consumer accepts current bit pair.
REQ-010 out_valid  output  1  a/b carry a valid bit pair.
REQ-011 a  output  1  current serial bit of operand A.
REQ-012 b  output  1  current serial bit of operand B.
REQ-013 out_first  output  1  current bit pair is the first of its word.
REQ-014 out_last  output  1  current bit pair is the last of its word.

Function
REQ-015 Input handshake: word accepted on a posedge where in_valid && in_ready; in_a/in_b captured into internal shift registers.
REQ-016 Output handshake: bit pair consumed on a posedge where out_valid && out_ready; the next bit pair is presented after that edge.
REQ-017 FSM states: IDLE (no word held, out_valid=0) and SHIFT (word held, out_valid=1).
REQ-018 IDLE -> SHIFT on input acceptance; SHIFT -> IDLE when the last bit is consumed and no new word is accepted in the same cycle; SHIFT -> SHIFT (reload) when the last bit is consumed and a new word is accepted in the same cycle.
REQ-019 in_ready = (state == IDLE) || (out_valid && out_ready && out_last); the out_ready -> in_ready combinational path is intended.
REQ-020 a, b, out_valid, out_first, out_last SHALL be registered outputs.
REQ-021 Latency: a word accepted at edge k presents its first bit pair from edge k until the first out_ready-qualified edge.
REQ-022 Bit order: MSB_FIRST=1 emits bit WIDTH-1 down to bit 0; MSB_FIRST=0 emits bit 0 up to bit WIDTH-1.
REQ-023 Bit counter width is ceil(log2(WIDTH)), minimum 1 bit; it counts 0..WIDTH-1, advances only on consumption, and clears on load.
REQ-024 out_first=1 exactly while bit index 0 of a word is presented; out_last=1 exactly while bit index WIDTH-1 is presented; with WIDTH=1 both are 1.
REQ-025 While out_valid && !out_ready, a, b, out_first, out_last and internal state SHALL hold unchanged.
REQ-026 Back-to-back words SHALL stream with no idle cycle between the last bit of one word and the first bit of the next.
REQ-027 in_valid while in SHIFT and not at a consumed last bit: in_ready=0 and the offered word is not captured.
REQ-028 In IDLE, a and b SHALL be 0.

Reset
REQ-029 rst_n=0 at a posedge SHALL force IDLE, out_valid=0, out_first=0, out_last=0, a=0, b=0, counter=0; in_ready=1 on the following cycle.
REQ-030 Reset mid-word SHALL discard the remaining bits; no partial word resumes after reset.
REQ-031 in_valid is ignored while rst_n=0; no word is accepted on a reset edge.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, out_ready=1, in_a=8'hB4, in_b=8'h3C -> a=1,0,1,1,0,1,0,0; b=0,0,1,1,1,1,0,0; out_first on bit 0; out_last on bit 7; then out_valid=0.
REQ-033 Same inputs, MSB_FIRST=0 -> a=0,0,1,0,1,1,0,1; b=0,0,1,1,1,1,0,0.
REQ-034 Backpressure: out_ready=0 for 2 cycles while bit 3 is presented -> a, b, out_first, out_last stable; total sequence unchanged; 10 out_valid cycles.
REQ-035 Back-to-back: in_valid held with 8'hFF/8'h00 then 8'h00/8'hFF, out_ready=1 -> 16 contiguous out_valid cycles; out_first at cycles 0 and 8; in_ready=1 only in IDLE and on cycle 7.
REQ-036 Busy rejection: new in_valid at bit 2 -> in_ready=0; that word is never emitted unless held until cycle 7.
REQ-037 Reset mid-word: rst_n=0 for one edge at bit 4 -> next cycle out_valid=0, in_ready=1, a=b=0; the next accepted word starts with out_first=1.
